// File: rtl/mseq_pkg.sv
// Shared constants and state encoding for the M-sequence controller slice.
package mseq_pkg;
    localparam int             DEF_WIDTH  = 4;
    localparam logic [3:0]     DEF_SEED   = 4'b0001;
    localparam int             DEF_MAXPER = 15;
    localparam int             PER_W      = 5;

    typedef enum logic [1:0] {IDLE, SYNC, RUN, ERR} state_t;
endpackage

// File: rtl/mseq_period.sv
// Capture counter and period measurement; flags zero-state and missing seed return.
module mseq_period
    import mseq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MAXPER = DEF_MAXPER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             capture,
    input  logic [WIDTH-1:0] fase_new,
    input  logic [WIDTH-1:0] seed,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             hit_zero,
    output logic             hit_timeout
);
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] cnt_inc;
    logic             match;

    assign cnt_inc     = cnt + PER_W'(1);
    assign match       = (fase_new == seed);
    assign hit_zero    = (fase_new == '0);
    // A seed return on the final allowed capture still counts as a valid period.
    assign hit_timeout = !match && (cnt_inc == PER_W'(MAXPER + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (capture) begin
                if (match && !hit_zero) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: rtl/mseq_ctrl.sv
// Sequencing FSM around the mfun stage: load, sync, capture, chip output, error flags.
module mseq_ctrl
    import mseq_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
    parameter int               MAXPER = DEF_MAXPER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] poly_in,
    output logic [WIDTH-1:0] fase,
    output logic [WIDTH-1:0] type_f,
    input  logic [WIDTH-1:0] fase_new,
    input  logic             control,
    output logic             chip,
    output logic             chip_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             busy,
    output logic             stuck,
    output logic             timeout
);
    state_t           state, state_n;
    logic [WIDTH-1:0] seed_q, seed_n, fase_n, type_n;
    logic             chip_n, chip_valid_n, stuck_n, timeout_n;
    logic             load, capture, hit_zero, hit_timeout;

    mseq_period #(.WIDTH(WIDTH), .MAXPER(MAXPER)) u_period (
        .clk          (clk),
        .rst          (rst),
        .clear        (load),
        .capture      (capture),
        .fase_new     (fase_new),
        .seed         (seed_q),
        .period       (period),
        .period_valid (period_valid),
        .hit_zero     (hit_zero),
        .hit_timeout  (hit_timeout)
    );

    always_comb begin
        state_n      = state;
        fase_n       = fase;
        type_n       = type_f;
        seed_n       = seed_q;
        chip_n       = chip;
        chip_valid_n = 1'b0;
        stuck_n      = stuck;
        timeout_n    = timeout;
        load         = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE, ERR: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    load = 1'b1;
                end
            end
            SYNC: begin
                // First strobe may reflect the pre-load state, so it is dropped.
                if (stop)         state_n = IDLE;
                else if (control) state_n = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (control) begin
                    capture      = 1'b1;
                    chip_n       = fase[0];
                    chip_valid_n = 1'b1;
                    fase_n       = fase_new;
                    if (hit_zero) begin
                        stuck_n = 1'b1;
                        state_n = ERR;
                    end else if (hit_timeout) begin
                        timeout_n = 1'b1;
                        state_n   = ERR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            fase_n    = (seed_in == '0) ? SEED : seed_in;
            seed_n    = fase_n;
            type_n    = poly_in;
            stuck_n   = 1'b0;
            timeout_n = 1'b0;
            state_n   = SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fase       <= '0;
            type_f     <= '0;
            seed_q     <= '0;
            chip       <= 1'b0;
            chip_valid <= 1'b0;
            busy       <= 1'b0;
            stuck      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            fase       <= fase_n;
            type_f     <= type_n;
            seed_q     <= seed_n;
            chip       <= chip_n;
            chip_valid <= chip_valid_n;
            busy       <= (state_n == SYNC) || (state_n == RUN);
            stuck      <= stuck_n;
            timeout    <= timeout_n;
        end
    end
endmodule

// File: doc/mseq_ctrl.md
Name: mseq_ctrl

Overview:
State/sequencing controller closing the loop around the mfun M-sequence stage. Loads seed and tap word, drives fase/type_f into mfun and captures fase_new on each control strobe. Emits the serial chip stream and measures the sequence period. Flags lock-up (all-zero state) and failure to return to the seed.

Parameters:
WIDTH, 4, state/tap width; must match mfun.
SEED, 4'b0001, substitute seed used when seed_in is all-zero.
MAXPER, 15, maximum legal period; capture count MAXPER+1 without seed return raises timeout.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse: load seed/poly and begin.
stop  in  1  one-cycle pulse: abort to IDLE.
seed_in  in  WIDTH  initial state.
poly_in  in  WIDTH  tap word.
fase  out  WIDTH  current state, to mfun.fase.
type_f  out  WIDTH  latched tap word, to mfun.type_f.
fase_new  in  WIDTH  next state from mfun.
control  in  1  mfun update strobe; fase_new valid in the same cycle.
chip  out  1  serial output bit.
chip_valid  out  1  one-cycle pulse qualifying chip.
period  out  5  last measured period.
period_valid  out  1  one-cycle pulse when period updates.
busy  out  1  high in SYNC/RUN.
stuck  out  1  sticky: all-zero state captured.
timeout  out  1  sticky: no seed return within MAXPER+1 captures.

Behaviour:
- Reset values: all outputs 0; fase=0, type_f=0; state IDLE; internal seed register and capture count cnt = 0.
- All outputs registered; a capture at edge N (control=1 sampled) updates outputs after edge N.
- States: IDLE, SYNC, RUN, ERR.
- IDLE:
  - On start: fase <= (seed_in==0 ? SEED : seed_in); the same value goes to the internal seed register.
  - type_f <= poly_in; cnt <= 0; stuck/timeout cleared; go to SYNC.
- SYNC:
  - First control pulse is discarded: no capture, no chip. mfun may have computed it from the pre-load fase.
  - Go to RUN on that pulse.
- RUN, on control=1:
  - chip <= fase[0] (pre-update LSB); chip_valid <= 1; fase <= fase_new; cnt <= cnt+1.
  - If fase_new == seed: period <= cnt+1; period_valid <= 1; cnt <= 0; stay in RUN. The period is re-measured every cycle of the sequence.
  - If fase_new == 0: stuck <= 1; go to ERR. fase still updates to 0, chip still emitted.
  - Else if cnt+1 == MAXPER+1: timeout <= 1; go to ERR.
  - Zero check has priority over the seed match. The seed is never 0, so these two cannot coincide.
- RUN, control=0: fase and type_f held constant. mfun requires fase stable between strobes.
- ERR:
  - fase/type_f hold; busy=0; stuck/timeout remain set; control ignored.
  - start re-enters the load path as from IDLE.
- stop in SYNC/RUN/ERR: go to IDLE next edge; fase/type_f hold; flags hold; pulses cleared.
- Simultaneous events:
  - start+stop in IDLE: stop wins, remain IDLE.
  - start in SYNC/RUN: ignored.
  - control in the same cycle as stop: capture suppressed.
- rst at any time overrides everything and returns all outputs to reset values at that edge.
- chip_valid and period_valid are exactly one cycle wide. Back-to-back control pulses (delay=0) yield back-to-back valids.

Decomposition:
- Shared package mseq_pkg: WIDTH, SEED, MAXPER defaults; state encoding enum {IDLE, SYNC, RUN, ERR}; period width constant (5).
- One natural sub-module: mseq_period, holding the cnt register, seed comparator, zero detect and timeout compare. It outputs period/period_valid/hit_zero/hit_timeout to the FSM.

Test Plan:
1. rst, then start with seed_in=4'b1001, poly_in=4'b0011 -> next cycle fase=9, type_f=3, busy=1; first control pulse with fase_new=4 -> no chip_valid, fase stays 9.
2. In RUN, drive control pulses with fase_new=4, 2, 9 -> chip=1, 0, 0 with chip_valid each; fase=4, 2, 9; period=3 with period_valid on the third capture; busy stays 1.
3. start with seed_in=0 -> fase=4'b0001. Then in RUN, fase_new=0 -> stuck=1, busy=0, fase=0, further control pulses produce no chip_valid.
4. Seed 4'b0001, drive 16 captures alternating fase_new=3, 5 -> timeout=1 on the 16th capture, state ERR, period_valid never asserted.
5. stop mid-RUN together with control=1 -> no capture, IDLE next cycle, fase held. start+stop same cycle in IDLE -> stays IDLE.
6. rst asserted mid-RUN with control=1 -> all outputs 0 on that edge; a subsequent start behaves as scenario 1.
